// File: rtl/obj_pkg.sv
// Shared types and constants for the obstacle-avoidance controller:
// state codes, turn-direction latch values and motor command encoding.
package obj_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_STOP   = 3'd2,
        ST_REV    = 3'd3,
        ST_TURN_L = 3'd4,
        ST_TURN_R = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        DIR_AMBIG = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_e;

    localparam logic [1:0] MOT_STOP = 2'b00;
    localparam logic [1:0] MOT_FWD  = 2'b01;
    localparam logic [1:0] MOT_REV  = 2'b10;

    typedef struct packed {
        logic [1:0] left;
        logic [1:0] right;
    } motor_cmd_t;

    function automatic motor_cmd_t motor_decode(input state_e st);
        motor_cmd_t cmd;
        case (st)
            ST_FWD:    begin cmd.left = MOT_FWD;  cmd.right = MOT_FWD;  end
            ST_REV:    begin cmd.left = MOT_REV;  cmd.right = MOT_REV;  end
            ST_TURN_L: begin cmd.left = MOT_REV;  cmd.right = MOT_FWD;  end
            ST_TURN_R: begin cmd.left = MOT_FWD;  cmd.right = MOT_REV;  end
            default:   begin cmd.left = MOT_STOP; cmd.right = MOT_STOP; end
        endcase
        return cmd;
    endfunction

    function automatic logic is_busy(input state_e st);
        logic b;
        case (st)
            ST_STOP, ST_REV, ST_TURN_L, ST_TURN_R: b = 1'b1;
            default:                               b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/obj_dwell_timer.sv
// Dwell counter shared by all timed states: restarts on clear and flags
// expire during the last cycle of a dwell of length limit.
module obj_dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] count_r;

    // counter register: zero on reset or state entry, otherwise counts up
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= CNT_ZERO;
        end else if (clear) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_r + CNT_ONE;
        end
    end

    assign expire = (count_r == (limit - CNT_ONE));

endmodule

// File: rtl/obj_avoid_ctrl.sv
// Obstacle-avoidance motion controller: FWD / STOP / REV / TURN maneuver FSM
// with registered Moore outputs. Optional OBJ_AVOID_STATS_EN adds maneuver_count.
module obj_avoid_ctrl
    import obj_pkg::*;
#(
    parameter int STOP_CYCLES = 2,
    parameter int REV_CYCLES  = 8,
    parameter int TURN_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        left_object_detected,
    input  logic        right_object_detected,
    input  logic        front_object_detected,
    output logic [1:0]  motor_left,
    output logic [1:0]  motor_right,
    output logic        busy,
    output logic [2:0]  state_o,
    output logic        maneuver_done
`ifdef OBJ_AVOID_STATS_EN
    ,
    output logic [15:0] maneuver_count
`endif
);

    localparam logic [CNT_W-1:0] STOP_LIM = CNT_W'(STOP_CYCLES);
    localparam logic [CNT_W-1:0] REV_LIM  = CNT_W'(REV_CYCLES);
    localparam logic [CNT_W-1:0] TURN_LIM = CNT_W'(TURN_CYCLES);

    state_e           state_r;
    state_e           state_nxt_s;
    dir_e             dir_r;
    dir_e             dir_nxt_s;
    logic             alt_r;
    logic             alt_nxt_s;
    logic             done_nxt_s;
    logic [CNT_W-1:0] limit_s;
    logic             clear_s;
    logic             expire_s;
    motor_cmd_t       motor_nxt_s;

    obj_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear_s),
        .limit  (limit_s),
        .expire (expire_s)
    );

    // next-state, turn-direction latch and completion decode
    always_comb begin
        state_nxt_s = state_r;
        dir_nxt_s   = dir_r;
        alt_nxt_s   = alt_r;
        done_nxt_s  = 1'b0;
        limit_s     = TURN_LIM;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_FWD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FWD: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (front_object_detected ||
                             (left_object_detected && right_object_detected)) begin
                    state_nxt_s = ST_STOP;
                    // steer away from the single blocked side; anything else is ambiguous
                    if (left_object_detected && !right_object_detected) begin
                        dir_nxt_s = DIR_RIGHT;
                    end else if (right_object_detected && !left_object_detected) begin
                        dir_nxt_s = DIR_LEFT;
                    end else begin
                        dir_nxt_s = DIR_AMBIG;
                    end
                end else if (left_object_detected) begin
                    state_nxt_s = ST_TURN_R;
                end else if (right_object_detected) begin
                    state_nxt_s = ST_TURN_L;
                end else begin
                    state_nxt_s = ST_FWD;
                end
            end
            ST_STOP: begin
                limit_s = STOP_LIM;
                if (expire_s) begin
                    state_nxt_s = ST_REV;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_REV: begin
                limit_s = REV_LIM;
                if (expire_s) begin
                    case (dir_r)
                        DIR_LEFT:  state_nxt_s = ST_TURN_L;
                        DIR_RIGHT: state_nxt_s = ST_TURN_R;
                        default: begin
                            // alternate sides so repeated head-on blocks do not loop
                            if (alt_r) begin
                                state_nxt_s = ST_TURN_L;
                            end else begin
                                state_nxt_s = ST_TURN_R;
                            end
                            alt_nxt_s = ~alt_r;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_REV;
                end
            end
            ST_TURN_L, ST_TURN_R: begin
                limit_s = TURN_LIM;
                if (expire_s) begin
                    done_nxt_s = 1'b1;
                    if (enable) begin
                        state_nxt_s = ST_FWD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign clear_s     = (state_nxt_s != state_r);
    assign motor_nxt_s = motor_decode(state_nxt_s);
    assign state_o     = state_r;

    // state, latches and registered Moore outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            dir_r         <= DIR_AMBIG;
            alt_r         <= 1'b0;
            motor_left    <= MOT_STOP;
            motor_right   <= MOT_STOP;
            busy          <= 1'b0;
            maneuver_done <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            dir_r         <= dir_nxt_s;
            alt_r         <= alt_nxt_s;
            motor_left    <= motor_nxt_s.left;
            motor_right   <= motor_nxt_s.right;
            busy          <= is_busy(state_nxt_s);
            maneuver_done <= done_nxt_s;
        end
    end

`ifdef OBJ_AVOID_STATS_EN
    // saturating count of completed maneuvers
    always_ff @(posedge clk) begin
        if (!reset) begin
            maneuver_count <= 16'h0000;
        end else if (done_nxt_s && (maneuver_count != 16'hFFFF)) begin
            maneuver_count <= maneuver_count + 16'h0001;
        end else begin
            maneuver_count <= maneuver_count;
        end
    end
`endif

endmodule

// File: tb/tb_obj_avoid_ctrl.sv
// Directed, table-driven bench for obj_avoid_ctrl with default parameters,
// plus hand-written maneuver sequences for the timed corner cases.
module tb_obj_avoid_ctrl;

    localparam logic [1:0] M_S = 2'b00;
    localparam logic [1:0] M_F = 2'b01;
    localparam logic [1:0] M_R = 2'b10;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FWD  = 3'd1;
    localparam logic [2:0] S_STOP = 3'd2;
    localparam logic [2:0] S_REV  = 3'd3;
    localparam logic [2:0] S_TL   = 3'd4;
    localparam logic [2:0] S_TR   = 3'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       left_det;
    logic       right_det;
    logic       front_det;
    logic [1:0] motor_left;
    logic [1:0] motor_right;
    logic       busy;
    logic [2:0] state_o;
    logic       maneuver_done;
`ifdef OBJ_AVOID_STATS_EN
    logic [15:0] maneuver_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    obj_avoid_ctrl dut (
        .clk                   (clk),
        .reset                 (reset),
        .enable                (enable),
        .left_object_detected  (left_det),
        .right_object_detected (right_det),
        .front_object_detected (front_det),
        .motor_left            (motor_left),
        .motor_right           (motor_right),
        .busy                  (busy),
        .state_o               (state_o),
        .maneuver_done         (maneuver_done)
`ifdef OBJ_AVOID_STATS_EN
        ,
        .maneuver_count        (maneuver_count)
`endif
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       l;
        logic       r;
        logic       f;
        logic [2:0] st;
        logic [1:0] ml;
        logic [1:0] mr;
        logic       bsy;
        logic       done;
    } vec_t;

    vec_t vecs[10];

    task automatic tick(input logic rst_i, input logic en_i, input logic l_i,
                        input logic r_i, input logic f_i);
        reset     = rst_i;
        enable    = en_i;
        left_det  = l_i;
        right_det = r_i;
        front_det = f_i;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] st, input logic [1:0] ml,
                       input logic [1:0] mr, input logic bsy, input logic done);
        logic [8:0] act;
        logic [8:0] exp;
        act = {state_o, motor_left, motor_right, busy, maneuver_done};
        exp = {st, ml, mr, bsy, done};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d ml=%b mr=%b busy=%b done=%b, want st=%0d ml=%b mr=%b busy=%b done=%b",
                     name, state_o, motor_left, motor_right, busy, maneuver_done,
                     st, ml, mr, bsy, done);
        end
    endtask

    task automatic phase(input string name, input int n, input logic en_i, input logic l_i,
                         input logic r_i, input logic f_i, input logic [2:0] st,
                         input logic [1:0] ml, input logic [1:0] mr, input logic bsy);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, en_i, l_i, r_i, f_i);
            chk(name, st, ml, mr, bsy, 1'b0);
        end
    endtask

    task automatic stats_chk(input string name, input logic [15:0] exp);
`ifdef OBJ_AVOID_STATS_EN
        checks++;
        if (maneuver_count !== exp) begin
            errors++;
            $display("FAIL %s: got maneuver_count=%0d, want %0d", name, maneuver_count, exp);
        end
`else
        if (exp == 16'hFFFF) $display("note: %s unused", name);
`endif
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; left_det = 1'b0; right_det = 1'b0; front_det = 1'b0;

        //            rst   en    l     r     f     st      ml   mr   busy  done
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, S_IDLE, M_S, M_S, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, S_IDLE, M_S, M_S, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, S_IDLE, M_S, M_S, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, M_S, M_S, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, S_IDLE, M_S, M_S, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_FWD,  M_F, M_F, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, S_IDLE, M_S, M_S, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, S_FWD,  M_F, M_F, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_FWD,  M_F, M_F, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, S_TR,   M_F, M_R, 1'b1, 1'b0};

        for (int i = 0; i < 10; i++) begin
            tick(vecs[i].rst, vecs[i].en, vecs[i].l, vecs[i].r, vecs[i].f);
            chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].ml, vecs[i].mr,
                vecs[i].bsy, vecs[i].done);
        end
        stats_chk("count_after_reset", 16'd0);

        // left-only turn from the table: 15 more TURN_R cycles then completion
        phase("left_turn", 15, 1'b1, 1'b0, 1'b0, 1'b0, S_TR, M_F, M_R, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("left_turn_done", S_FWD, M_F, M_F, 1'b0, 1'b1);
        stats_chk("count_1", 16'd1);

        // front pulse: ambiguous, toggle 0 -> TURN_R; flags during REV are ignored
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("front_stop", S_STOP, M_S, M_S, 1'b1, 1'b0);
        phase("front_stop", 1, 1'b1, 1'b0, 1'b0, 1'b0, S_STOP, M_S, M_S, 1'b1);
        phase("front_rev", 8, 1'b1, 1'b1, 1'b0, 1'b1, S_REV, M_R, M_R, 1'b1);
        phase("front_turn", 16, 1'b1, 1'b0, 1'b0, 1'b0, S_TR, M_F, M_R, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("front_done", S_FWD, M_F, M_F, 1'b0, 1'b1);
        stats_chk("count_2", 16'd2);

        // back-to-back ambiguous maneuver turns the other way
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("front2_stop", S_STOP, M_S, M_S, 1'b1, 1'b0);
        phase("front2_stop", 1, 1'b1, 1'b0, 1'b0, 1'b0, S_STOP, M_S, M_S, 1'b1);
        phase("front2_rev", 8, 1'b1, 1'b0, 1'b0, 1'b0, S_REV, M_R, M_R, 1'b1);
        phase("front2_turn", 16, 1'b1, 1'b0, 1'b0, 1'b0, S_TL, M_R, M_F, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("front2_done", S_FWD, M_F, M_F, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("front2_pulse_end", S_FWD, M_F, M_F, 1'b0, 1'b0);
        stats_chk("count_3", 16'd3);

        // right-only goes straight to TURN_L
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("right_turn", S_TL, M_R, M_F, 1'b1, 1'b0);
        phase("right_turn", 15, 1'b1, 1'b0, 1'b1, 1'b0, S_TL, M_R, M_F, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("right_done", S_FWD, M_F, M_F, 1'b0, 1'b1);

        // enable dropped during REV: maneuver completes (TURN_R), then IDLE
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("dis_stop", S_STOP, M_S, M_S, 1'b1, 1'b0);
        phase("dis_stop", 1, 1'b1, 1'b0, 1'b0, 1'b0, S_STOP, M_S, M_S, 1'b1);
        phase("dis_rev_en", 3, 1'b1, 1'b0, 1'b0, 1'b0, S_REV, M_R, M_R, 1'b1);
        phase("dis_rev_off", 5, 1'b0, 1'b0, 1'b0, 1'b0, S_REV, M_R, M_R, 1'b1);
        phase("dis_turn", 16, 1'b0, 1'b0, 1'b0, 1'b0, S_TR, M_F, M_R, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("dis_done", S_IDLE, M_S, M_S, 1'b0, 1'b1);
        phase("dis_idle", 2, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, M_S, M_S, 1'b0);
        stats_chk("count_5", 16'd5);

        // front with right also set latches a left turn; reset on TURN_L cycle 5
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_fwd", S_FWD, M_F, M_F, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("rst_stop", S_STOP, M_S, M_S, 1'b1, 1'b0);
        phase("rst_stop", 1, 1'b1, 1'b0, 1'b0, 1'b0, S_STOP, M_S, M_S, 1'b1);
        phase("rst_rev", 8, 1'b1, 1'b0, 1'b0, 1'b0, S_REV, M_R, M_R, 1'b1);
        phase("rst_turn", 4, 1'b1, 1'b0, 1'b0, 1'b0, S_TL, M_R, M_F, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_turn", S_IDLE, M_S, M_S, 1'b0, 1'b0);
        stats_chk("count_cleared", 16'd0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_idle", S_IDLE, M_S, M_S, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_refwd", S_FWD, M_F, M_F, 1'b0, 1'b0);

        // dwell counter restarts: full 16-cycle turn after the reset
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_rst_turn", S_TR, M_F, M_R, 1'b1, 1'b0);
        phase("post_rst_turn", 15, 1'b1, 1'b0, 1'b0, 1'b0, S_TR, M_F, M_R, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_done", S_FWD, M_F, M_F, 1'b0, 1'b1);
        stats_chk("count_after_rst", 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obj_avoid_ctrl.md
# obj_avoid_ctrl

Obstacle-avoidance motion controller that consumes the three detection flags produced by the object detector (`left_object_detected`, `right_object_detected`, `front_object_detected`) and drives the left/right motor commands. It runs a timed maneuver state machine: drive forward, stop, reverse, turn away, then resume. It sits directly downstream of the detector top in the robot datapath.

## Interface
Parameters:
- STOP_CYCLES, 2: cycles held in STOP, ≥1
- REV_CYCLES, 8: cycles held in REV, ≥1
- TURN_CYCLES, 16: cycles held in TURN_L/TURN_R, ≥1
- CNT_W, 8: dwell counter width; must hold max(parameters)−1

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on clk rising edge
- enable  in  1  run request
- left_object_detected  in  1  detector flag
- right_object_detected  in  1  detector flag
- front_object_detected  in  1  detector flag
- motor_left  out  2  00 stop, 01 forward, 10 reverse (11 never driven)
- motor_right  out  2  same encoding
- busy  out  1  high in STOP, REV, TURN_L, TURN_R
- state_o  out  3  current state code
- maneuver_done  out  1  one-cycle pulse on maneuver completion

## Operation
- States and codes: IDLE=0, FWD=1, STOP=2, REV=3, TURN_L=4, TURN_R=5.
- Reset (reset==0 at an edge):
  - state IDLE, counter 0, dir latch 0, alt toggle 0.
  - All outputs 0: motors 00, busy 0, state_o 0, maneuver_done 0.
  - Reset overrides any maneuver in progress.
- IDLE: motors 00/00. enable=1 → FWD.
- FWD: motors 01/01. Priority order:
  - enable=0 → IDLE.
  - front=1, or left&right=1 → STOP. Latch dir on this transition: left-only→right turn, right-only→left turn, otherwise ambiguous.
  - left-only (front=0) → TURN_R directly.
  - right-only (front=0) → TURN_L directly.
  - else stay in FWD.
- STOP: motors 00/00 for STOP_CYCLES cycles, then REV.
- REV: motors 10/10 for REV_CYCLES cycles, then the turn given by the dir latch. When dir is ambiguous, use the alt toggle (0→TURN_R, 1→TURN_L) and invert the toggle.
- TURN_L: motor_left=10, motor_right=01. TURN_R: motor_left=01, motor_right=10. Each lasts TURN_CYCLES cycles.
- On leaving a turn: go to FWD if enable=1, IDLE if enable=0. Pulse maneuver_done.
- In STOP/REV/TURN, detection inputs and enable are ignored. Maneuvers are non-abortable except by reset.
- Dwell counter: cleared on state entry, increments each cycle. The state exits on the edge where counter==N−1, so each state lasts exactly N cycles.

## Timing
- Outputs are registered and Moore-decoded from the state register. A flag sampled at edge k appears as a motor change in the cycle after edge k (1-cycle latency).
- Full front maneuver from FWD, with defaults: 2 cycles STOP + 8 cycles REV + 16 cycles TURN = 26 cycles busy.
- maneuver_done is high for exactly the first cycle after the final turn cycle, coincident with state_o becoming FWD or IDLE.
- A detection still present on the first FWD cycle after a maneuver is acted on at the next edge. Back-to-back maneuvers are legal.
- Simultaneous enable=0 and front=1 in FWD: enable wins, go to IDLE.

## Configuration
- OBJ_AVOID_STATS_EN defined:
  - Adds output `maneuver_count` (16 bits).
  - Increments on every maneuver_done pulse and saturates at 16'hFFFF.
  - Cleared by reset.
- Not defined: the port and the counter logic are absent; all other behaviour is identical.

## Structure
- Shared package obj_pkg holds:
  - state enum and codes
  - motor encoding constants MOT_STOP=2'b00, MOT_FWD=2'b01, MOT_REV=2'b10
- Sub-module obj_dwell_timer:
  - inputs: clear, limit; output: expire at count==limit−1
  - CNT_W parameter
  - instantiated once and reused across states

## Test plan
- Reset: hold reset=0 for 3 cycles with all flags=1 → motors 00/00, state_o=0, busy=0, maneuver_done=0.
- Front obstacle: enable=1, front pulsed for 1 cycle in FWD → STOP 2 cycles, REV 8 cycles, TURN_R 16 cycles (ambiguous dir, toggle=0), then maneuver_done=1 for 1 cycle and state_o=1.
- Second ambiguous maneuver: repeat the front pulse → turn is TURN_L (toggle alternates). With OBJ_AVOID_STATS_EN, maneuver_count=2.
- Side-only: left=1 in FWD → next cycle state_o=5, motors 01/10 for 16 cycles. right=1 → state_o=4, motors 10/01.
- Disable mid-maneuver: drop enable during REV → maneuver completes, then state_o=0 with a single maneuver_done pulse. enable=0 together with front=1 in FWD → IDLE, no STOP.
- Reset mid-turn: reset=0 at cycle 5 of TURN_L → next cycle all outputs 0 and state IDLE. Counter is restarted from 0 on the next maneuver.
